// File: rtl/approx_multiplier_seq.sv
// Iterative shift-and-add unsigned multiplier with valid/ready handshakes.
// Approximate mode drops the low TRUNC_BITS columns of every partial product.
module approx_multiplier_seq #(
    parameter int WIDTH      = 8,
    parameter int TRUNC_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 approx_en_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 approx_o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    // Keeps product columns at or above TRUNC_BITS; all ones when TRUNC_BITS is 0.
    localparam logic [PW-1:0] KEEP_MASK = ~({PW{1'b1}} >> (PW - TRUNC_BITS));

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc;
    logic            approx_q;
    logic            out_valid_q;
    logic [PW-1:0]   pp;

    // a_sh holds a << cnt and b_sh[0] is b[cnt], so no barrel shifter is needed.
    always_comb begin
        pp = '0;
        if (b_sh[0]) begin
            pp = approx_q ? (a_sh & KEEP_MASK) : a_sh;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            cnt         <= '0;
            acc         <= '0;
            approx_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_sh     <= {{WIDTH{1'b0}}, a_i};
                        b_sh     <= b_i;
                        approx_q <= approx_en_i;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc  <= acc + pp;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Gated by rst_i so the producer never sees ready while reset is asserted.
    assign in_ready_o  = (state == IDLE) && !rst_i;
    assign out_valid_o = out_valid_q;
    assign product_o   = acc;
    assign approx_o    = approx_q;

endmodule

// File: tb/tb_approx_multiplier_seq.sv
// Directed self-checking bench: three instances covering the default,
// zero-truncation and full-truncation configurations.
module tb_approx_multiplier_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8, TRUNC_BITS=4
    logic        v8 = 0, r8 = 0, ap8 = 0, ir8, ov8, apo8;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] p8;
    // WIDTH=4, TRUNC_BITS=0
    logic        v4 = 0, ap4 = 0, ir4, ov4, apo4;
    logic [3:0]  a4 = 0, b4 = 0;
    logic [7:0]  p4;
    // WIDTH=16, TRUNC_BITS=32
    logic        v16 = 0, ap16 = 0, ir16, ov16, apo16;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] p16;

    approx_multiplier_seq #(.WIDTH(8), .TRUNC_BITS(4)) dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v8), .in_ready_o(ir8),
        .a_i(a8), .b_i(b8), .approx_en_i(ap8), .out_valid_o(ov8),
        .out_ready_i(r8), .product_o(p8), .approx_o(apo8)
    );

    approx_multiplier_seq #(.WIDTH(4), .TRUNC_BITS(0)) dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v4), .in_ready_o(ir4),
        .a_i(a4), .b_i(b4), .approx_en_i(ap4), .out_valid_o(ov4),
        .out_ready_i(1'b1), .product_o(p4), .approx_o(apo4)
    );

    approx_multiplier_seq #(.WIDTH(16), .TRUNC_BITS(32)) dut16 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v16), .in_ready_o(ir16),
        .a_i(a16), .b_i(b16), .approx_en_i(ap16), .out_valid_o(ov16),
        .out_ready_i(1'b1), .product_o(p16), .approx_o(apo16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8();
        for (int n = 0; n < 20 && !ir8; n++) tick();
    endtask

    // Accept one operation on dut8 and count edges until out_valid rises.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ap, output int edges);
        wait_ready8();
        a8 = a; b8 = b; ap8 = ap; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        edges = 0;
        while (!ov8 && edges < 30) begin
            tick();
            edges++;
        end
    endtask

    task automatic finish8();
        r8 = 1'b1;
        tick();
        r8 = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[16] = '{
        '{8'd1,   8'd1,   16'd1},     '{8'd2,   8'd3,   16'd6},
        '{8'd12,  8'd12,  16'd144},   '{8'd255, 8'd1,   16'd255},
        '{8'd1,   8'd255, 16'd255},   '{8'd16,  8'd16,  16'd256},
        '{8'd100, 8'd100, 16'd10000}, '{8'd200, 8'd3,   16'd600},
        '{8'd128, 8'd2,   16'd256},   '{8'd17,  8'd15,  16'd255},
        '{8'd99,  8'd7,   16'd693},   '{8'd250, 8'd250, 16'd62500},
        '{8'd13,  8'd11,  16'd143},   '{8'd64,  8'd64,  16'd4096},
        '{8'd0,   8'd77,  16'd0},     '{8'd254, 8'd255, 16'd64770}
    };

    initial begin
        int edges;
        int last_cyc;

        // Reset state
        #2;
        check("rst_in_ready", ir8, 0);
        check("rst_out_valid", ov8, 0);
        check("rst_product", p8, 0);
        check("rst_approx", apo8, 0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", ir8, 1);

        // Exact 255*255 with latency
        run8(8'd255, 8'd255, 1'b0, edges);
        check("exact_ff_valid", ov8, 1);
        check("exact_ff_latency", edges, 8);
        check("exact_ff_product", p8, 65025);
        check("exact_ff_approx", apo8, 0);
        check("done_in_ready", ir8, 0);
        finish8();

        // Approximate cases
        run8(8'd255, 8'd255, 1'b1, edges);
        check("approx_ff_latency", edges, 8);
        check("approx_ff_product", p8, 64976);
        check("approx_ff_approx", apo8, 1);
        finish8();
        run8(8'd3, 8'd5, 1'b1, edges);
        check("approx_3x5", p8, 0);
        finish8();
        run8(8'd3, 8'd5, 1'b0, edges);
        check("exact_3x5", p8, 15);
        finish8();

        // Backpressure with ignored in_valid
        run8(8'd10, 8'd20, 1'b0, edges);
        check("bp_product", p8, 200);
        for (int i = 0; i < 5; i++) begin
            a8 = 8'd7; b8 = 8'd9; v8 = 1'b1;
            tick();
            check("bp_hold_product", p8, 200);
            check("bp_hold_valid", ov8, 1);
            check("bp_hold_in_ready", ir8, 0);
        end
        v8 = 1'b0;
        r8 = 1'b1;
        tick();
        r8 = 1'b0;
        check("bp_release_valid", ov8, 0);
        check("bp_release_in_ready", ir8, 1);
        run8(8'd7, 8'd9, 1'b0, edges);
        check("bp_next_product", p8, 63);
        finish8();

        // Asynchronous reset mid-operation
        wait_ready8();
        a8 = 8'd255; b8 = 8'd255; ap8 = 1'b0; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("midrst_valid", ov8, 0);
        check("midrst_product", p8, 0);
        check("midrst_in_ready", ir8, 0);
        tick();
        check("midrst_hold_in_ready", ir8, 0);
        rst = 1'b0;
        #1;
        check("midrst_release_in_ready", ir8, 1);
        run8(8'd0, 8'd200, 1'b0, edges);
        check("midrst_next_latency", edges, 8);
        check("midrst_next_product", p8, 0);
        finish8();

        // Back-to-back with out_ready held high
        r8 = 1'b1;
        ap8 = 1'b0;
        last_cyc = 0;
        for (int k = 0; k < 16; k++) begin
            wait_ready8();
            a8 = vecs[k].a; b8 = vecs[k].b; v8 = 1'b1;
            tick();
            for (int n = 0; n < 30 && !ov8; n++) tick();
            check("b2b_product", p8, vecs[k].p);
            if (k > 0) check("b2b_interval", cyc - last_cyc, 10);
            last_cyc = cyc;
        end
        v8 = 1'b0;
        tick();
        r8 = 1'b0;

        // WIDTH=4, no truncation: approximate equals exact
        a4 = 4'd15; b4 = 4'd15; ap4 = 1'b1; v4 = 1'b1;
        tick();
        v4 = 1'b0;
        for (int n = 0; n < 20 && !ov4; n++) tick();
        check("w4_valid", ov4, 1);
        check("w4_product", p4, 225);
        check("w4_approx", apo4, 1);
        tick();

        // WIDTH=16, full truncation: always zero
        a16 = 16'd65535; b16 = 16'd65535; ap16 = 1'b1; v16 = 1'b1;
        tick();
        v16 = 1'b0;
        for (int n = 0; n < 40 && !ov16; n++) tick();
        check("w16_valid", ov16, 1);
        check("w16_product_max", p16, 0);
        check("w16_approx", apo16, 1);
        tick();
        for (int n = 0; n < 5 && !ir16; n++) tick();
        a16 = 16'd1234; b16 = 16'd5678; v16 = 1'b1;
        tick();
        v16 = 1'b0;
        for (int n = 0; n < 40 && !ov16; n++) tick();
        check("w16_valid_2", ov16, 1);
        check("w16_product_2", p16, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
